lfsr_checker: RTL

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Serial checker for the 6-bit Galois generator stream.
// It seeds a 6-bit history from the received stream and then predicts each
// valid bit with a[t] = a[t-6] ^ a[t-4] ^ a[t-3]. It flags mispredictions and
// drops lock when the leaky miss counter reaches LOSS_THRESH.
module lfsr_checker #(
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned HIST_W = 6;
  localparam int unsigned FCNT_W = 3;
  localparam int unsigned MISS_W = 4;

  // fcnt value reached on the sixth seeding bit
  localparam logic [FCNT_W-1:0] FILL_LAST = FCNT_W'(HIST_W - 1);
  // miss value at which lock is abandoned
  localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(LOSS_THRESH);
  // saturation value of the error counter
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [HIST_W-1:0]   hist;
  logic [HIST_W-1:0]   hist_nxt;
  logic [FCNT_W-1:0]   fcnt;
  logic [FCNT_W-1:0]   fcnt_nxt;
  logic [MISS_W-1:0]   miss;
  logic [MISS_W-1:0]   miss_nxt;
  logic [MISS_W-1:0]   miss_inc;
  logic [CNT_W-1:0]    cnt_base;
  logic [CNT_W-1:0]    err_cnt_nxt;
  logic [HIST_W-1:0]   hist_shift;
  logic                pred;
  logic                mismatch;
  logic                locked_nxt;

  // Received-bit history shift and prediction from the oldest taps.
  assign hist_shift = {hist[HIST_W-2:0], din};
  assign pred       = hist[5] ^ hist[3] ^ hist[2];
  assign mismatch   = (state == CHECK) && din_valid && (din != pred);
  assign miss_inc   = miss + MISS_W'(1);

  // Next-state: seeding fill, lock acquisition and lock loss.
  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    fcnt_nxt  = fcnt;
    miss_nxt  = miss;
    if (din_valid) begin
      hist_nxt = hist_shift;
      case (state)
        SEED: begin
          if (fcnt == FILL_LAST) begin
            // An all-zero history can never come from the generator, so
            // only a nonzero seed is accepted; otherwise start a new fill.
            fcnt_nxt = '0;
            if (hist_shift != '0) begin
              state_nxt = CHECK;
              miss_nxt  = '0;
            end
          end else begin
            fcnt_nxt = fcnt + FCNT_W'(1);
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (miss_inc == MISS_DROP) begin
              state_nxt = SEED;
              fcnt_nxt  = '0;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss_inc;
            end
          end else if (miss != '0) begin
            miss_nxt = miss - MISS_W'(1);
          end
        end
      endcase
    end
  end

  // Error counter: clear applies first, then a saturating increment.
  always_comb begin
    cnt_base    = clr ? '0 : err_cnt;
    err_cnt_nxt = cnt_base;
    if (mismatch && (cnt_base != CNT_MAX)) begin
      err_cnt_nxt = cnt_base + CNT_W'(1);
    end
  end

  // locked tracks the state being entered so it equals (state == CHECK).
  assign locked_nxt = (state_nxt == CHECK);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= SEED;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist    <= '0;
      fcnt    <= '0;
      miss    <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      hist    <= hist_nxt;
      fcnt    <= fcnt_nxt;
      miss    <= miss_nxt;
      locked  <= locked_nxt;
      err     <= mismatch;
      err_cnt <= err_cnt_nxt;
    end
  end

endmodule
